// File: rtl/nru_req_sequencer.sv
// Command sequencer for the NRU way-partitioned cache: queues domain switches and
// user accesses, issues them to the cache one at a time and tallies hit/miss/switch stats.
module nru_req_sequencer #(
    parameter int NUM_WAYS   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_is_switch,
    input  logic [NUM_WAYS-1:0]   cmd_hitmap,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  os_req,
    output logic [NUM_WAYS-1:0]   hitmap,
    output logic                  user_req,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic                  hit,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    input  logic                  clear_counts,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [CNT_WIDTH-1:0]  switch_count,
    output logic                  err_no_domain,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + NUM_WAYS + ADDR_WIDTH;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE_OS, ISSUE_USER, WAIT_HIT} state_t;

    state_t                state, state_nxt;
    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full, empty, push, pop, ready_en;
    logic [ENT_W-1:0]      head;
    logic                  head_sw;
    logic [NUM_WAYS-1:0]   head_hm;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  os_nxt, user_nxt, rsp_nxt, sw_inc, drop;
    logic                  load_domain, load_addr;

    // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
    // the offer may be held or withdrawn freely while cmd_ready is low.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = ready_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE) || !empty;
    assign dbg_state = state;

    assign head      = fifo_mem[rd_ptr];
    assign head_sw   = head[ENT_W-1];
    assign head_hm   = head[ADDR_WIDTH +: NUM_WAYS];
    assign head_addr = head[ADDR_WIDTH-1:0];

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        os_nxt      = 1'b0;
        user_nxt    = 1'b0;
        rsp_nxt     = 1'b0;
        sw_inc      = 1'b0;
        drop        = 1'b0;
        load_domain = 1'b0;
        load_addr   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_sw) begin
                        load_domain = 1'b1;
                        os_nxt      = 1'b1;
                        state_nxt   = ISSUE_OS;
                    end else if (hitmap != '0) begin
                        load_addr = 1'b1;
                        user_nxt  = 1'b1;
                        state_nxt = ISSUE_USER;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ISSUE_OS: begin
                sw_inc    = 1'b1;
                state_nxt = IDLE;
            end
            ISSUE_USER: state_nxt = WAIT_HIT;
            // hit is valid here: the cache registered it on the edge that saw user_req
            WAIT_HIT: begin
                rsp_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_is_switch, cmd_hitmap, cmd_addr};
    end

    // hitmap doubles as the stored domain, so it always reflects the last switch issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ready_en      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            os_req        <= 1'b0;
            user_req      <= 1'b0;
            hitmap        <= '0;
            addr          <= '0;
            rsp_valid     <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_addr      <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            switch_count  <= '0;
            err_no_domain <= 1'b0;
        end else begin
            state     <= state_nxt;
            ready_en  <= 1'b1;
            os_req    <= os_nxt;
            user_req  <= user_nxt;
            rsp_valid <= rsp_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load_domain) hitmap <= head_hm;
            if (load_addr)   addr   <= head_addr;
            if (rsp_nxt) begin
                rsp_hit  <= hit;
                rsp_addr <= addr;
            end
            if (drop) err_no_domain <= 1'b1;
            if (clear_counts) begin
                hit_count    <= '0;
                miss_count   <= '0;
                switch_count <= '0;
            end else begin
                if (sw_inc)          switch_count <= sat_inc(switch_count);
                if (rsp_nxt && hit)  hit_count    <= sat_inc(hit_count);
                if (rsp_nxt && !hit) miss_count   <= sat_inc(miss_count);
            end
        end
    end

endmodule

// File: doc/nru_req_sequencer.md
Name: nru_req_sequencer

Overview:
- Request initiator for the NRU way-partitioned cache model.
- Buffers a stream of commands in a small FIFO. A command is either a domain switch (hitmap) or a user access (address).
- Drives the cache's os_req/hitmap and user_req/addr pins one request at a time, then samples the cache's registered hit flag.
- Reports a per-access result and keeps saturating hit/miss/switch statistics. Used as the stimulus and scoreboard front-end in cache security experiments.

Parameters:
- NUM_WAYS, 8, number of cache ways (width of hitmap)
- ADDR_WIDTH, 8, tag/address width
- FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
- CNT_WIDTH, 16, width of each statistics counter

Ports:
- clk  in  1  clock; all state changes on posedge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; transfer when cmd_valid && cmd_ready
- cmd_is_switch  in  1  1 = domain switch, 0 = user access
- cmd_hitmap  in  NUM_WAYS  hitmap for a switch command
- cmd_addr  in  ADDR_WIDTH  address for a user access
- os_req  out  1  to cache: domain switch request
- hitmap  out  NUM_WAYS  to cache: hitmap, valid with os_req
- user_req  out  1  to cache: access request
- addr  out  ADDR_WIDTH  to cache: access address, valid with user_req
- hit  in  1  from cache: registered hit result
- rsp_valid  out  1  one-cycle pulse per completed user access
- rsp_hit  out  1  hit result, valid with rsp_valid
- rsp_addr  out  ADDR_WIDTH  address of completed access
- clear_counts  in  1  synchronous clear of statistics
- hit_count, miss_count, switch_count  out  CNT_WIDTH each  saturating counters
- err_no_domain  out  1  sticky: user access dropped because the current domain hitmap is 0
- busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (async, reset_n=0): all outputs 0. FIFO emptied. Stored domain hitmap = 0. FSM = IDLE. In-flight request abandoned; no rsp_valid. cmd_ready rises the first cycle after release.
- All cache-facing outputs are registered. os_req and user_req are never high in the same cycle and each is high for exactly one cycle per request. hitmap/addr hold their last value when not requesting.
- FIFO: cmd_ready = !full. Simultaneous push and pop are allowed when not full. A push while full cannot occur. Commands are strictly in order.
- FSM states: IDLE, ISSUE_OS, ISSUE_USER, WAIT_HIT.
- IDLE with FIFO empty: stay in IDLE.
- IDLE with a switch command at the head: pop it, latch hitmap into the stored domain, go to ISSUE_OS.
- IDLE with a user command at the head and stored domain != 0: pop it, go to ISSUE_USER.
- IDLE with a user command at the head and stored domain == 0: pop it, set err_no_domain, stay in IDLE. No cache request is issued and counters are unchanged.
- ISSUE_OS: os_req=1 with hitmap = stored domain. switch_count +1. Then go to IDLE.
- ISSUE_USER: user_req=1 with addr. Then go to WAIT_HIT. The cache updates hit on the edge that samples user_req.
- WAIT_HIT: sample hit at the end of this cycle. Next cycle: rsp_valid=1, rsp_hit=sampled value, rsp_addr=addr; hit_count or miss_count +1. Then go to IDLE.
- Throughput: a switch takes 2 cycles per command and a user access takes 3 cycles, measured from the IDLE pop.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- clear_counts zeroes all three counters. If it coincides with an increment, the clear wins and the increment is lost. clear_counts does not affect err_no_domain, which is cleared only by reset.
- A switch to hitmap 0 is legal and is issued to the cache. Subsequent user commands are dropped with err_no_domain set.
- busy = (state != IDLE) || !empty.

Test Plan:
- Reset, then push user addr 0x12 with no prior switch -> user_req never asserts, err_no_domain=1, hit_count=miss_count=0, busy low 2 cycles after the push.
- With the cache model connected, push switch 0x0F, user 0x12, user 0x12 -> one os_req pulse with hitmap=0x0F; responses are rsp_hit=0 then rsp_hit=1, rsp_addr=0x12 both times; switch_count=1, miss_count=1, hit_count=1.
- Push 6 commands on consecutive cycles (FIFO_DEPTH=4) -> cmd_ready drops when full, no command lost or reordered, cache requests follow push order exactly.
- CNT_WIDTH=2, domain 0xFF, 5 distinct addresses -> miss_count saturates at 3, no wrap.
- Assert reset_n=0 during WAIT_HIT -> user_req/os_req/rsp_valid 0 immediately, counters 0, FIFO empty, no response after release.
- clear_counts asserted in the same cycle as rsp_valid for a miss -> all counters 0 next cycle.
